// File: rtl/mv_pkg.sv
// mv_pkg: shared types and constants for the matrix-vector MAC sequencer.
//   state_t      - sequencer FSM states
//   DRAIN_CYCLES - cycles spent waiting for the MAC pipeline to empty
//   clog2w()     - ceil(log2(value)) clamped to a minimum of 1 bit
package mv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Memory read latency (1) plus operand register stage (1).
  localparam int DRAIN_CYCLES = 2;

  function automatic int clog2w(input int value);
    return (value < 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/mv_mac_sequencer_mac_lane.sv
// mac_lane: one registered signed multiply-accumulate lane.
// Operands are captured when in_valid is high; on the following cycle the
// product is either loaded (first) or added into the accumulator.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   in_valid in   a/b carry a valid operand pair this cycle
//   first    in   operand pair is the first of a dot product (clear-and-load)
//   a, b     in   DW-bit signed operands
//   acc      out  AW-bit signed accumulator, wraps modulo 2^AW
module mac_lane #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          first,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  logic signed [DW-1:0] a_q;
  logic signed [DW-1:0] b_q;
  logic                 v_q;
  logic                 f_q;
  logic signed [AW-1:0] prod;

  // Signed size casts sign-extend both operands to AW; since AW >= 2*DW the
  // low AW bits of the product are the exact product sign-extended.
  assign prod = AW'(a_q) * AW'(b_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= 1'b0;
      f_q <= 1'b0;
      acc <= '0;
    end else begin
      v_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
        f_q <= first;
      end
      if (v_q) begin
        acc <= f_q ? prod : acc + prod;
      end
    end
  end

endmodule

// File: rtl/mv_mac_sequencer.sv
// mv_mac_sequencer: steps one MAC lane through an M x N matrix times
// N-vector product, one row at a time, publishing one result per row.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   begin a new product (honoured only in IDLE)
//   busy       out  FSM not in IDLE
//   done       out  one-cycle pulse when the last row is written
//   mat_rd_en  out  read strobe for both external memories
//   mat_addr   out  row-major matrix address (row*N + col)
//   vec_addr   out  vector address (col)
//   mat_data   in   matrix element, valid the cycle after mat_rd_en
//   vec_data   in   vector element, valid the cycle after mat_rd_en
//   res_valid  out  result slot occupied
//   res_ready  in   consumer takes the result when res_valid && res_ready
//   res_row    out  row index of res_data
//   res_data   out  signed row dot product
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | one read per cycle for col 0..N-1 of the current row
// DRAIN | DRAIN_CYCLES cycles for the last operands to reach the accumulator
// WRITE | move accumulator into result slot once it is free
module mv_mac_sequencer
  import mv_pkg::*;
#(
  parameter int M   = 4,
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int AW  = 16,
  parameter int MAW = clog2w(M * N),
  parameter int VAW = clog2w(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mat_rd_en,
  output logic [MAW-1:0]       mat_addr,
  output logic [VAW-1:0]       vec_addr,
  input  logic [DW-1:0]        mat_data,
  input  logic [DW-1:0]        vec_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [clog2w(M)-1:0] res_row,
  output logic [AW-1:0]        res_data
);

  localparam int RW  = clog2w(M);
  localparam int DCW = clog2w(DRAIN_CYCLES);

  localparam logic [RW-1:0]  ROW_LAST = RW'(M - 1);
  localparam logic [VAW-1:0] COL_LAST = VAW'(N - 1);
  localparam logic [DCW-1:0] DC_LOAD  = DCW'(DRAIN_CYCLES - 1);

  state_t         state;
  logic [RW-1:0]  row;
  logic [VAW-1:0] col;
  logic [DCW-1:0] drain_cnt;

  // Read strobe delayed to line up with the returning memory data.
  logic           rd_d1;
  logic           first_d1;
  logic [AW-1:0]  acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_d1    <= 1'b0;
      first_d1 <= 1'b0;
    end else begin
      rd_d1    <= mat_rd_en;
      first_d1 <= mat_rd_en && (col == '0);
    end
  end

  mac_lane #(
    .DW(DW),
    .AW(AW)
  ) u_mac_lane (
    .clk      (clk),
    .reset    (reset),
    .in_valid (rd_d1),
    .first    (first_d1),
    .a        (mat_data),
    .b        (vec_data),
    .acc      (acc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mat_rd_en <= 1'b0;
      mat_addr  <= '0;
      vec_addr  <= '0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_data  <= '0;
    end else begin
      done <= 1'b0;
      // Consumer handshake; a WRITE reload below takes priority.
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            row       <= '0;
            col       <= '0;
            mat_rd_en <= 1'b1;
            mat_addr  <= '0;
            vec_addr  <= '0;
          end
        end

        ISSUE: begin
          if (col == COL_LAST) begin
            state     <= DRAIN;
            col       <= '0;
            mat_rd_en <= 1'b0;
            drain_cnt <= DC_LOAD;
          end else begin
            col      <= col + VAW'(1);
            vec_addr <= col + VAW'(1);
            mat_addr <= mat_addr + MAW'(1);
          end
        end

        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= WRITE;
          end else begin
            drain_cnt <= drain_cnt - DCW'(1);
          end
        end

        WRITE: begin
          if (!res_valid || res_ready) begin
            res_valid <= 1'b1;
            res_data  <= acc;
            res_row   <= row;
            if (row == ROW_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // mat_addr still holds row*N + N-1, so +1 is the next row start.
              state     <= ISSUE;
              row       <= row + RW'(1);
              mat_rd_en <= 1'b1;
              mat_addr  <= mat_addr + MAW'(1);
              vec_addr  <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_mac_sequencer.sv
module tb_mv_mac_sequencer;

  localparam int M   = 4;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int AW  = 16;
  localparam int MAW = 4;
  localparam int VAW = 2;
  localparam int RW  = 2;
  localparam int T_DONE = M * (N + 3);

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 start = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 mat_rd_en;
  logic [MAW-1:0]       mat_addr;
  logic [VAW-1:0]       vec_addr;
  logic [DW-1:0]        mat_data = '0;
  logic [DW-1:0]        vec_data = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [RW-1:0]        res_row;
  logic signed [AW-1:0] res_data;

  int total = 0;
  int bad = 0;

  logic signed [DW-1:0] mat [M*N];
  logic signed [DW-1:0] vec [N];

  int aq[$];
  int vq[$];
  int rrow[$];
  logic signed [AW-1:0] rdat[$];
  int done_cnt = 0;

  mv_mac_sequencer #(.M(M), .N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mat_rd_en (mat_rd_en),
    .mat_addr  (mat_addr),
    .vec_addr  (vec_addr),
    .mat_data  (mat_data),
    .vec_data  (vec_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_row   (res_row),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  // External synchronous memories: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mat_rd_en) begin
      mat_data <= mat[mat_addr];
      vec_data <= vec[vec_addr];
    end
  end

  always @(posedge clk) begin
    if (mat_rd_en) begin
      aq.push_back(int'(mat_addr));
      vq.push_back(int'(vec_addr));
    end
    if (res_valid && res_ready) begin
      rrow.push_back(int'(res_row));
      rdat.push_back(res_data);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Row dot product from plain integer arithmetic, wrapped to AW bits.
  function automatic logic signed [AW-1:0] ref_row(input int r);
    int s;
    s = 0;
    for (int j = 0; j < N; j++) s += int'(mat[r*N+j]) * int'(vec[j]);
    return AW'(s);
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < M*N; i++)
      mat[i] = (mode == 1) ? 8'sd127 : (mode == 2) ? -8'sd128 : DW'($urandom_range(0, 255));
    for (int j = 0; j < N; j++)
      vec[j] = (mode == 1) ? 8'sd127 : (mode == 2) ? -8'sd128 : DW'($urandom_range(0, 255));
  endtask

  // One full product. bp: hold res_ready low 8 cycles from the first result.
  // rnd: random res_ready. poke: pulse start again while busy.
  task automatic run(input bit bp, input bit rnd, input bit poke, output int n);
    int a_base, r_base, d_base;
    a_base = aq.size();
    r_base = rdat.size();
    d_base = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    n = 0;
    while (n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      if (bp && n >= N + 4 && n <= N + 11) begin
        chk("hold_row", res_row, 0);
        chk("hold_data", res_data, ref_row(0));
      end
      if (bp && (n == 2*(N+3) || n == 2*(N+3) + 1))
        chk("stall_no_issue", mat_rd_en, 0);
      res_ready = bp ? !(n >= N + 3 && n < N + 11) : rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (n == 3);
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    res_ready = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt - d_base, 1);
    chk("addr_count", aq.size() - a_base, M*N);
    for (int k = 0; k < M*N; k++) begin
      if (a_base + k < aq.size()) begin
        chk("mat_addr", aq[a_base+k], k);
        chk("vec_addr", vq[a_base+k], k % N);
      end
    end
    chk("res_count", rdat.size() - r_base, M);
    for (int r = 0; r < M; r++) begin
      if (r_base + r < rdat.size()) begin
        chk("res_row", rrow[r_base+r], r);
        chk("res_data", rdat[r_base+r], ref_row(r));
      end
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, mat_rd_en, mat_addr, vec_addr, res_valid, res_row, res_data}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Random matrices, free-flowing consumer; exact done timing
    for (int t = 0; t < 2; t++) begin
      fill(0);
      run(0, 0, 0, n);
      chk("done_cycle", n, T_DONE);
    end

    // Saturating magnitudes: 4*127*127 = 64516 wraps to -1020
    fill(1);
    run(0, 0, 0, n);
    chk("wrap127", rdat[rdat.size()-1], -1020);
    fill(2);
    run(0, 0, 0, n);
    chk("neg128", rdat[rdat.size()-1], 0);

    // Mixed signs: [-2,7,-1,0] . [4,3,-6,x] = 19
    fill(0);
    mat[0] = -8'sd2; mat[1] = 8'sd7; mat[2] = -8'sd1; mat[3] = 8'sd0;
    vec[0] = 8'sd4;  vec[1] = 8'sd3; vec[2] = -8'sd6;
    run(0, 0, 0, n);
    chk("mixed_row0", rdat[rdat.size()-M], 19);

    // Backpressure: ready low for result cycles N+4..N+11; row 1 WRITE
    // (cycle 2*(N+3)) waits until cycle N+12 -> 2 stall cycles.
    fill(0);
    run(1, 0, 0, n);
    chk("done_cycle_bp", n, T_DONE + (N + 12 - 2*(N+3)));

    // Start pulsed while busy is ignored
    fill(0);
    run(0, 0, 1, n);
    chk("done_cycle_poke", n, T_DONE);

    // Random consumer backpressure
    fill(0);
    run(0, 1, 0, n);

    // Reset during row 1 ISSUE, then a clean product
    fill(0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (N + 4) @(negedge clk);
    chk("rd_before_reset", mat_rd_en, 1);
    #1 reset = 1'b0;
    #1 chk("async_reset_outputs", {busy, done, mat_rd_en, mat_addr, vec_addr, res_valid, res_row, res_data}, 0);
    @(negedge clk);
    reset = 1'b1;
    fill(0);
    run(0, 0, 0, n);
    chk("done_cycle_after_reset", n, T_DONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
